// File: rtl/uart_pkg.sv
// Shared types and constants for the PicoSoC buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_LOW,
        BRK_MAB
    } tx_state_t;

    localparam int MIN_BRK_BITS = 12;
    localparam int MAB_BITS     = 2;

    // A break shorter than one full frame plus margin would look like a framing error.
    function automatic int unsigned brk_bit_count(input int unsigned len);
        return (len < MIN_BRK_BITS) ? MIN_BRK_BITS : len;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte push and break request channel between the SoC bus side and uart_tx_buffered.
interface uart_tx_buffered_if #(
    parameter int BRK_LEN_W = 8
);
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 brk_req;
    logic [BRK_LEN_W-1:0] brk_len;

    modport master (
        output tx_data, tx_valid, brk_req, brk_len,
        input  tx_ready
    );

    modport slave (
        input  tx_data, tx_valid, brk_req, brk_len,
        output tx_ready
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered level; full and empty derive from the level only.
module uart_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + (DEPTH_LOG2 + 1)'(1);
            end else if (!do_push && do_pop) begin
                level <= level - (DEPTH_LOG2 + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter with break generation.
// Optional CTS flow control is enabled by defining UART_TX_CTS_EN.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int BRK_LEN_W       = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              cfg_divider,
    uart_tx_buffered_if.slave        bus,
`ifdef UART_TX_CTS_EN
    input  logic                     ser_cts_n,
`endif
    output logic                     ser_tx,
    output logic                     busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level
);
    localparam int CNT_W = (BRK_LEN_W > 4) ? BRK_LEN_W : 4;

    tx_state_t        state;
    logic [31:0]      divcnt;
    logic             bit_end;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] brk_cnt;
    logic [CNT_W-1:0] brk_bits;
    logic             brk_pend;
    logic             brk_accept;
    logic             start_frame;
    logic             line_bit;
    logic             cts_ok;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cts_sync <= 2'b11;
        end else begin
            cts_sync <= {cts_sync[0], ser_cts_n};
        end
    end

    assign cts_ok = !cts_sync[1];
`else
    assign cts_ok = 1'b1;
`endif

    uart_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (bus.tx_valid),
        .push_data (bus.tx_data),
        .pop       (start_frame),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign bus.tx_ready = !fifo_full;
    assign busy         = (state != IDLE) || !fifo_empty || brk_pend;

    // 33-bit compare keeps a divider of all ones from wrapping to zero.
    assign bit_end    = {1'b0, divcnt} >= ({1'b0, cfg_divider} + 33'd1);
    assign brk_accept = bus.brk_req && !brk_pend && (state != BRK_LOW) && (state != BRK_MAB);

    // Chaining STOP straight into START keeps queued bytes free of idle gaps.
    assign start_frame = cts_ok && !brk_pend && !fifo_empty &&
                         ((state == IDLE) || ((state == STOP) && bit_end));

    always_comb begin
        line_bit = 1'b1;
        case (state)
            START, BRK_LOW: line_bit = 1'b0;
            DATA:           line_bit = shreg[0];
            default:        line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            divcnt   <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            brk_cnt  <= '0;
            brk_bits <= '0;
            brk_pend <= 1'b0;
            ser_tx   <= 1'b1;
        end else begin
            ser_tx <= line_bit;

            if (brk_accept) begin
                brk_pend <= 1'b1;
                brk_bits <= CNT_W'(brk_bit_count(32'(bus.brk_len)));
            end

            if (state != IDLE) begin
                divcnt <= bit_end ? '0 : divcnt + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (cts_ok && brk_pend) begin
                        brk_pend <= 1'b0;
                        brk_cnt  <= '0;
                        state    <= BRK_LOW;
                    end else if (start_frame) begin
                        shreg <= fifo_dout;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (start_frame) begin
                            shreg <= fifo_dout;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                BRK_LOW: begin
                    if (bit_end) begin
                        if (brk_cnt == brk_bits - CNT_W'(1)) begin
                            brk_cnt <= '0;
                            state   <= BRK_MAB;
                        end else begin
                            brk_cnt <= brk_cnt + CNT_W'(1);
                        end
                    end
                end
                BRK_MAB: begin
                    if (bit_end) begin
                        if (brk_cnt == CNT_W'(MAB_BITS - 1)) begin
                            state <= IDLE;
                        end else begin
                            brk_cnt <= brk_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
